fma_result_buffer: RTL and testbench
====================================

Name: fma_result_buffer

Overview:
- Sits directly downstream of the 5-stage FP32 FMA pipeline.
- The pipeline has no stall input and produces one result per cycle after a fixed latency. This block captures every result into a FIFO and presents it to the consumer over a valid/ready handshake.
- It also generates the issue credit (issue_ok) the upstream issuer must honour before pulsing the pipeline's valid_in. This guarantees that no result can arrive while the FIFO is full.
- Each stored result is tagged with a 4-bit IEEE class.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2; must be at least LATENCY for full throughput.
LATENCY, 5, pipeline valid_in-to-valid_out latency in cycles; used only by assertions.
CNT_W, $clog2(DEPTH+1), width of occupancy and in-flight counters.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
issue_valid  in  1  copy of the pipeline valid_in; one operation launched this cycle
issue_ok  out  1  credit available; the issuer may assert issue_valid this cycle
res_valid  in  1  pipeline valid_out
res_data  in  32  pipeline F_out
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_data  out  32  head result
out_class  out  4  head class {is_nan, is_inf, is_zero, is_denorm}
count  out  CNT_W  entries stored
inflight  out  CNT_W  operations issued but not yet returned
err_overflow  out  1  sticky: result arrived while FIFO was full and not popping
err_credit  out  1  sticky: issue_valid while issue_ok=0, or res_valid while inflight=0

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - count, inflight, read/write pointers = 0.
  - out_valid = 0, err_* = 0, issue_ok = 1.
  - out_data and out_class are don't-care while out_valid = 0.
  - Storage array is not reset.
- Push:
  - res_valid=1 writes {class(res_data), res_data} at wr_ptr and increments wr_ptr modulo DEPTH.
  - Accepted when count<DEPTH, or when count==DEPTH with a pop in the same cycle.
  - Otherwise the data is dropped, err_overflow sets on the next edge, and count is unchanged.
- Pop:
  - out_valid = (count!=0), combinational from count.
  - out_data and out_class read mem[rd_ptr] combinationally (first-word fall-through).
  - Pop occurs when out_valid && out_ready; rd_ptr increments modulo DEPTH.
- Count update:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - Push into an empty FIFO: data is visible on out_data the cycle after the edge. There is no same-cycle bypass.
- In-flight counter:
  - issue_valid increments it; res_valid decrements it.
  - Both in the same cycle: unchanged.
  - res_valid with inflight=0: counter stays 0 and err_credit sets.
- Credit:
  - issue_ok = (count + inflight) < DEPTH, combinational, with no dependence on this cycle's issue_valid or out_ready.
  - issue_valid while issue_ok=0 sets err_credit; inflight still increments, saturating at DEPTH.
- Classification (on res_data fields exp[30:23], frac[22:0]):
  - exp==FF, frac!=0: is_nan.
  - exp==FF, frac==0: is_inf.
  - exp==0, frac==0: is_zero.
  - exp==0, frac!=0: is_denorm.
  - Otherwise 0000.
- Sticky errors: clear only on rst.
- Reset mid-operation: all in-flight and stored results are discarded. Results the pipeline returns after reset are counted as credit errors if inflight=0. The system must therefore reset the pipeline together with this block.
- Assertions (simulation only):
  - Each res_valid follows a matching issue_valid LATENCY cycles earlier.
  - count+inflight never exceeds DEPTH when the issuer honours issue_ok.

Decomposition:
- Package fpu_fma_pkg:
  - FP32 field positions (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, FRAC_W=23).
  - EXP_ALL1=8'hFF.
  - Class bit indices CLS_NAN=3, CLS_INF=2, CLS_ZERO=1, CLS_DENORM=0.
- One combinational sub-module fp32_classify (32-bit in, 4-bit class out), reused later by the decode stage.
- FIFO storage, pointers and counters stay inline.

Test Plan:
- Reset, then 8 issues spaced LATENCY apart with out_ready=1 -> each res_data appears on out_data one cycle after its res_valid; count never exceeds 1; issue_ok stays 1.
- out_ready=0 and back-to-back issues while issue_ok=1 -> issue_ok drops when count+inflight=8; after all returns count=8, inflight=0; raising out_ready drains 8 entries in order with no err_*.
- Full FIFO, res_valid and pop in the same cycle -> accepted, count stays 8, no err_overflow. Full FIFO, res_valid without pop -> data dropped, err_overflow=1 from the next cycle.
- res_data 7FC00000 / 7F800000 / 80000000 / 00000001 / 3F800000 -> out_class 1000 / 0100 / 0010 / 0001 / 0000.
- res_valid with inflight=0 -> err_credit=1, inflight stays 0. issue_valid while issue_ok=0 -> err_credit=1.
- rst asserted asynchronously with count=5, inflight=3 -> out_valid=0, count=0, inflight=0, issue_ok=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/fpu_fma_pkg.sv
// Shared FP32 field layout and result-class encoding for the FMA datapath.
package fpu_fma_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_W   = 23;
  localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;

  localparam logic [EXP_W-1:0] EXP_ALL1 = 8'hFF;

  localparam int CLS_NAN    = 3;
  localparam int CLS_INF    = 2;
  localparam int CLS_ZERO   = 1;
  localparam int CLS_DENORM = 0;
  localparam int CLS_W      = 4;

  typedef logic [CLS_W-1:0] fp_class_t;

  typedef struct packed {
    fp_class_t   cls;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational IEEE-754 single-precision classifier: {nan, inf, zero, denorm}.
module fp32_classify
  import fpu_fma_pkg::*;
(
  input  logic [31:0] value,
  output fp_class_t   cls
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic              unused_sign;

  assign exp_f       = value[EXP_MSB:EXP_LSB];
  assign frac_f      = value[FRAC_W-1:0];
  assign unused_sign = value[SIGN_BIT];

  always_comb begin
    cls = '0;
    if (exp_f == EXP_ALL1) begin
      if (frac_f != '0) cls[CLS_NAN] = 1'b1;
      else              cls[CLS_INF] = 1'b1;
    end else if (exp_f == '0) begin
      if (frac_f == '0) cls[CLS_ZERO]   = 1'b1;
      else              cls[CLS_DENORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fma_result_buffer.sv
// Result FIFO behind the stall-free FMA pipeline, with issue credit so that
// a returning result always finds a free slot.
module fma_result_buffer
  import fpu_fma_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 5,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ok,
  input  logic             res_valid,
  input  logic [31:0]      res_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_class,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] inflight,
  output logic             err_overflow,
  output logic             err_credit
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fifo_entry_t      mem [DEPTH];
  fifo_entry_t      head;
  fp_class_t        res_class;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W:0]   occupied;
  logic             push;
  logic             pop;
  logic             ret;

  fp32_classify u_classify (
    .value (res_data),
    .cls   (res_class)
  );

  // Consumer handshake: a beat transfers on a rising edge where out_valid and
  // out_ready are both high; out_data/out_class hold the head until then.
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = res_valid && ((count != DEPTH_C) || pop);
  assign ret       = res_valid && (inflight != '0);
  assign head      = mem[rd_ptr];
  assign out_data  = head.data;
  assign out_class = head.cls;

  // Slots already promised (stored + still in the pipeline) bound new issues.
  assign occupied = {1'b0, count} + {1'b0, inflight};
  assign issue_ok = (occupied < {1'b0, DEPTH_C});

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cls: res_class, data: res_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      inflight     <= '0;
      err_overflow <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);

      if (issue_valid && !ret) begin
        if (inflight != DEPTH_C) inflight <= inflight + CNT_W'(1);
      end else if (!issue_valid && ret) begin
        inflight <= inflight - CNT_W'(1);
      end

      if (res_valid && !push) err_overflow <= 1'b1;
      if ((issue_valid && !issue_ok) || (res_valid && inflight == '0))
        err_credit <= 1'b1;
    end
  end

  // A credited result must trail its issue by exactly the pipeline latency,
  // and an honoured credit scheme never over-commits the FIFO.
  a_latency : assert property (@(posedge clk) disable iff (rst)
    (res_valid && inflight != '0) |-> $past(issue_valid, LATENCY));

  a_credit : assert property (@(posedge clk) disable iff (rst)
    !err_credit |-> (occupied <= {1'b0, DEPTH_C}));

endmodule

// File: tb/tb_fma_result_buffer.sv
// Directed bench: pipeline shift model, table-driven vectors and a scoreboard.
module tb_fma_result_buffer;
  import fpu_fma_pkg::*;

  localparam int DEPTH   = 8;
  localparam int LATENCY = 5;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef struct {
    logic [31:0] data;
    logic [3:0]  cls;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic             issue_ok;
  logic             res_valid;
  logic [31:0]      res_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [3:0]       out_class;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] inflight;
  logic             err_overflow;
  logic             err_credit;

  logic [31:0]        issue_data;
  logic               inj_valid;
  logic [31:0]        inj_data;
  logic [LATENCY-1:0] pipe_v;
  logic [31:0]        pipe_d [LATENCY];

  logic [35:0] exp_q[$];
  logic        sb_en;
  int          checks;
  int          errors;
  vec_t        spaced_tbl [8];
  vec_t        class_tbl  [8];

  always #5 clk = ~clk;

  fma_result_buffer #(.DEPTH(DEPTH), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ok     (issue_ok),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_class    (out_class),
    .count        (count),
    .inflight     (inflight),
    .err_overflow (err_overflow),
    .err_credit   (err_credit)
  );

  // Fixed-latency pipeline stand-in, reset together with the buffer.
  always @(posedge clk or posedge rst) begin
    if (rst) pipe_v <= '0;
    else     pipe_v <= {pipe_v[LATENCY-2:0], issue_valid};
  end

  always @(posedge clk) begin
    pipe_d[0] <= issue_data;
    for (int i = 1; i < LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
  end

  assign res_valid = pipe_v[LATENCY-1] | inj_valid;
  assign res_data  = inj_valid ? inj_data : pipe_d[LATENCY-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted pop must match the oldest expected result.
  always @(negedge clk) begin
    if (sb_en && !rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_pop: got %0h expected nothing", out_data);
      end else begin
        check("sb_head", {28'b0, out_class, out_data}, {28'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    issue_valid = 1'b0;
    inj_valid   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Launches one operation this cycle; the caller drops issue_valid when done.
  task automatic issue_op(input logic [31:0] data, input logic [3:0] cls);
    issue_valid = 1'b1;
    issue_data  = data;
    if (sb_en) exp_q.push_back({cls, data});
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sb_en  = 1'b0;
    spaced_tbl = '{
      '{32'h3F800000, 4'b0000}, '{32'h40490FDB, 4'b0000},
      '{32'h00000000, 4'b0010}, '{32'h7F800000, 4'b0100},
      '{32'hFFC00001, 4'b1000}, '{32'h007FFFFF, 4'b0001},
      '{32'hC2F60000, 4'b0000}, '{32'h80000000, 4'b0010}};
    class_tbl = '{
      '{32'h7FC00000, 4'b1000}, '{32'h7F800000, 4'b0100},
      '{32'h80000000, 4'b0010}, '{32'h00000001, 4'b0001},
      '{32'h3F800000, 4'b0000}, '{32'hFF800000, 4'b0100},
      '{32'h807FFFFF, 4'b0001}, '{32'h7F800001, 4'b1000}};

    rst = 1'b0; issue_valid = 1'b0; issue_data = '0;
    out_ready = 1'b0; inj_valid = 1'b0; inj_data = '0;
    #2;
    do_reset();
    check("rst_count", 64'(count), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_issue_ok", 64'(issue_ok), 64'd1);
    check("rst_errs", {62'b0, err_overflow, err_credit}, 64'd0);

    // Spaced issues: each result visible one cycle after its res_valid.
    sb_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_op(spaced_tbl[i].data, spaced_tbl[i].cls);
      issue_valid = 1'b0;
      repeat (4) tick();
      check("t1_no_bypass", 64'(out_valid), 64'd0);
      tick();
      check("t1_out_valid", 64'(out_valid), 64'd1);
      check("t1_count", 64'(count), 64'd1);
      check("t1_issue_ok", 64'(issue_ok), 64'd1);
    end
    tick();
    check("t1_empty", 64'(count), 64'd0);

    // Back-to-back fill with consumer stalled, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t2_credit_open", 64'(issue_ok), 64'd1);
      issue_op(32'h41000000 + 32'(i), 4'b0000);
    end
    issue_valid = 1'b0;
    check("t2_credit_closed", 64'(issue_ok), 64'd0);
    check("t2_committed", 64'(count) + 64'(inflight), 64'd8);
    repeat (5) tick();
    check("t2_full_count", 64'(count), 64'd8);
    check("t2_full_inflight", 64'(inflight), 64'd0);
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    check("t2_drained", 64'(count), 64'd0);
    check("t2_no_err", {62'b0, err_overflow, err_credit}, 64'd0);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Full FIFO: push with pop accepted, push without pop dropped.
    do_reset();
    for (int i = 0; i < 8; i++) issue_op(32'h3F000000 + 32'(i), 4'b0000);
    issue_valid = 1'b0;
    repeat (5) tick();
    check("t3_full", 64'(count), 64'd8);
    out_ready = 1'b1;
    inj_valid = 1'b1;
    inj_data  = 32'h42280000;
    exp_q.push_back({4'b0000, 32'h42280000});
    tick();
    out_ready = 1'b0;
    inj_data  = 32'hDEADBEEF;
    check("t3_pushpop_count", 64'(count), 64'd8);
    check("t3_pushpop_no_ovf", 64'(err_overflow), 64'd0);
    tick();
    inj_valid = 1'b0;
    check("t3_drop_count", 64'(count), 64'd8);
    check("t3_overflow", 64'(err_overflow), 64'd1);
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    check("t3_sb_drained", 64'(exp_q.size()), 64'd0);
    check("t3_empty", 64'(count), 64'd0);
    sb_en = 1'b0;

    // Classification table, read back entry by entry.
    do_reset();
    for (int i = 0; i < 8; i++) issue_op(class_tbl[i].data, class_tbl[i].cls);
    issue_valid = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 8; i++) begin
      check("cls_valid", 64'(out_valid), 64'd1);
      check("cls_data", 64'(out_data), 64'(class_tbl[i].data));
      check("cls_class", 64'(out_class), 64'(class_tbl[i].cls));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("cls_no_err", {62'b0, err_overflow, err_credit}, 64'd0);

    // Asynchronous reset with five stored and three in flight.
    do_reset();
    for (int i = 0; i < 8; i++) issue_op(32'h40000000 + 32'(i), 4'b0000);
    issue_valid = 1'b0;
    tick();
    tick();
    check("ar_pre_count", 64'(count), 64'd5);
    check("ar_pre_inflight", 64'(inflight), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_count", 64'(count), 64'd0);
    check("ar_inflight", 64'(inflight), 64'd0);
    check("ar_issue_ok", 64'(issue_ok), 64'd1);
    tick();
    rst = 1'b0;
    tick();

    // Result with nothing in flight.
    check("ce_pre", 64'(err_credit), 64'd0);
    inj_valid = 1'b1;
    inj_data  = 32'h3F800000;
    tick();
    inj_valid = 1'b0;
    check("ce_orphan_err", 64'(err_credit), 64'd1);
    check("ce_orphan_inflight", 64'(inflight), 64'd0);
    check("ce_orphan_stored", 64'(count), 64'd1);

    // Issue without credit.
    do_reset();
    for (int i = 0; i < 8; i++) issue_op(32'h40800000 + 32'(i), 4'b0000);
    check("ci_closed", 64'(issue_ok), 64'd0);
    check("ci_pre", 64'(err_credit), 64'd0);
    issue_op(32'h40A00000, 4'b0000);
    issue_valid = 1'b0;
    check("ci_err", 64'(err_credit), 64'd1);
    check("ci_inflight", 64'(inflight), 64'd5);
    do_reset();
    check("ci_reset_clear", {62'b0, err_overflow, err_credit}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
